// File: rtl/sram_1w1r_mbist.sv
// March C- self-test controller for one 1W1R OpenRAM macro.
// Passes functional traffic through when idle and owns both macro ports while a test runs.
module sram_1w1r_mbist #(
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned DATA_WIDTH   = 40,
  parameter int unsigned MASK_WIDTH   = 4,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            err_count,
  input  logic [ADDR_WIDTH-1:0] f_waddr,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  input  logic                  f_wen,
  input  logic [MASK_WIDTH-1:0] f_wmask,
  input  logic [ADDR_WIDTH-1:0] f_raddr,
  input  logic                  f_ren,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic [MASK_WIDTH-1:0] wmask0,
  output logic                  csb0,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic                  csb1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CntW-1:0] DrainLast = CntW'(READ_LATENCY - 1);
  // Pipe entry layout: {valid, addr, elem, expected bit}
  localparam int unsigned PipeW = ADDR_WIDTH + 5;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                r_state, w_state_d;
  logic [2:0]            r_elem, w_elem_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic                  r_phase, w_phase_d;
  logic [CntW-1:0]       r_drain, w_drain_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic                  w_clear;

  logic w_single, w_desc, w_last, w_rd, w_rd_exp, w_wr_bit;

  // Elements 0 and 5 take one cycle per address; 1..4 are a read then a write.
  assign w_single = (r_elem == 3'd0) || (r_elem == 3'd5);
  assign w_desc   = (r_elem >= 3'd3);
  assign w_last   = w_desc ? (r_addr == '0) : (r_addr == LastAddr);
  assign w_rd     = (r_state == StRun) && ((r_elem == 3'd5) || (!w_single && !r_phase));
  assign w_rd_exp = (r_elem == 3'd2) || (r_elem == 3'd4);
  assign w_wr_bit = (r_elem == 3'd1) || (r_elem == 3'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_elem  <= '0;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_elem  <= w_elem_d;
      r_addr  <= w_addr_d;
      r_phase <= w_phase_d;
      r_drain <= w_drain_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_elem_d  = r_elem;
    w_addr_d  = r_addr;
    w_phase_d = r_phase;
    w_drain_d = r_drain;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_clear   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StRun;
          w_elem_d  = '0;
          w_addr_d  = '0;
          w_phase_d = 1'b0;
          w_busy_d  = 1'b1;
          w_done_d  = 1'b0;
          w_clear   = 1'b1;
        end
      end
      StRun: begin
        if (!w_single) w_phase_d = ~r_phase;
        if (w_single || r_phase) begin
          if (w_last) begin
            if (r_elem == 3'd5) begin
              w_state_d = StDrain;
              w_drain_d = '0;
            end else begin
              w_elem_d = r_elem + 3'd1;
              w_addr_d = (r_elem >= 3'd2) ? LastAddr : '0;
            end
          end else if (w_desc) begin
            w_addr_d = r_addr - ADDR_WIDTH'(1);
          end else begin
            w_addr_d = r_addr + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (r_drain == DrainLast) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
        end else begin
          w_drain_d = r_drain + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Macro pins: both chip selects held inactive throughout reset.
  always_comb begin
    csb0   = 1'b1;
    csb1   = 1'b1;
    addr0  = r_addr;
    addr1  = r_addr;
    din0   = {DATA_WIDTH{w_wr_bit}};
    wmask0 = '1;
    if (reset_n) begin
      if (r_state == StIdle) begin
        csb0   = ~f_wen;
        csb1   = ~f_ren;
        addr0  = f_waddr;
        addr1  = f_raddr;
        din0   = f_wdata;
        wmask0 = f_wmask;
      end else if (r_state == StRun) begin
        csb0 = w_rd;
        csb1 = ~w_rd;
      end
    end
  end

  logic [PipeW-1:0]      r_pipe [READ_LATENCY];
  logic [PipeW-1:0]      w_pout;
  logic                  w_o_valid, w_o_exp, w_mismatch;
  logic [ADDR_WIDTH-1:0] w_o_addr;
  logic [2:0]            w_o_elem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_rd, r_addr, r_elem, w_rd_exp};
      for (int i = 1; i < int'(READ_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_pout     = r_pipe[READ_LATENCY-1];
  assign w_o_valid  = w_pout[PipeW-1];
  assign w_o_addr   = w_pout[PipeW-2 -: ADDR_WIDTH];
  assign w_o_elem   = w_pout[3:1];
  assign w_o_exp    = w_pout[0];
  assign w_mismatch = w_o_valid && (dout1 != {DATA_WIDTH{w_o_exp}});

  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [2:0]            r_fail_elem;
  logic [7:0]            r_err_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_err_count <= '0;
    end else if (w_clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_err_count <= '0;
    end else if (w_mismatch) begin
      r_fail <= 1'b1;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      if (!r_fail) begin
        r_fail_addr <= w_o_addr;
        r_fail_elem <= w_o_elem;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign err_count = r_err_count;
  assign f_rdata   = dout1;

endmodule

// File: tb/tb_sram_1w1r_mbist.sv
// Bench for sram_1w1r_mbist: two instances (default, and DEPTH=38/ADDR_WIDTH=6/READ_LATENCY=2)
// each driving a behavioural macro with injectable stuck-at read faults.
module tb_sram_1w1r_mbist;
  localparam int DW = 40;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          start_a, busy_a, done_a, fail_a, f_wen_a, f_ren_a, csb0_a, csb1_a;
  logic [6:0]    fail_addr_a, f_waddr_a, f_raddr_a, addr0_a, addr1_a;
  logic [2:0]    fail_elem_a;
  logic [7:0]    err_a;
  logic [DW-1:0] f_wdata_a, f_rdata_a, din0_a, dout_a;
  logic [MW-1:0] f_wmask_a, wmask0_a;

  logic          start_b, busy_b, done_b, fail_b, f_wen_b, f_ren_b, csb0_b, csb1_b;
  logic [5:0]    fail_addr_b, f_waddr_b, f_raddr_b, addr0_b, addr1_b;
  logic [2:0]    fail_elem_b;
  logic [7:0]    err_b;
  logic [DW-1:0] f_wdata_b, f_rdata_b, din0_b, dout_b, d1_b;
  logic [MW-1:0] f_wmask_b, wmask0_b;

  sram_1w1r_mbist u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .fail(fail_a), .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .err_count(err_a),
    .f_waddr(f_waddr_a), .f_wdata(f_wdata_a), .f_wen(f_wen_a), .f_wmask(f_wmask_a),
    .f_raddr(f_raddr_a), .f_ren(f_ren_a), .f_rdata(f_rdata_a), .addr0(addr0_a),
    .din0(din0_a), .wmask0(wmask0_a), .csb0(csb0_a), .addr1(addr1_a), .csb1(csb1_a),
    .dout1(dout_a)
  );

  sram_1w1r_mbist #(.ADDR_WIDTH(6), .DEPTH(38), .READ_LATENCY(2)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .fail(fail_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .err_count(err_b),
    .f_waddr(f_waddr_b), .f_wdata(f_wdata_b), .f_wen(f_wen_b), .f_wmask(f_wmask_b),
    .f_raddr(f_raddr_b), .f_ren(f_ren_b), .f_rdata(f_rdata_b), .addr0(addr0_b),
    .din0(din0_b), .wmask0(wmask0_b), .csb0(csb0_b), .addr1(addr1_b), .csb1(csb1_b),
    .dout1(dout_b)
  );

  // Stuck-at masks applied to read data, per instance and address.
  logic [DW-1:0] sa0 [2][128];
  logic [DW-1:0] sa1 [2][128];
  logic [DW-1:0] mem_a [128];
  logic [DW-1:0] mem_b [64];

  always @(posedge clock) begin
    if (!csb0_a)
      for (int m = 0; m < MW; m++)
        if (wmask0_a[m]) mem_a[addr0_a][m*10 +: 10] <= din0_a[m*10 +: 10];
    if (!csb1_a) dout_a <= (mem_a[addr1_a] & ~sa0[0][addr1_a]) | sa1[0][addr1_a];
  end

  always @(posedge clock) begin
    if (!csb0_b)
      for (int m = 0; m < MW; m++)
        if (wmask0_b[m]) mem_b[addr0_b][m*10 +: 10] <= din0_b[m*10 +: 10];
    if (!csb1_b) d1_b <= (mem_b[addr1_b] & ~sa0[1][addr1_b]) | sa1[1][addr1_b];
    dout_b <= d1_b;
  end

  typedef struct {
    int cycles; int fl; int faddr; int felem; int errs; int rds; int wrs; int maxa;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ncmp, nfail;
  bit   rnd_f;
  int   bcyc [2], nrd [2], nwr [2], maxa [2], nboth [2];
  bit   pbusy [2];

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    ncmp++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Reference: walk the March C- table over an ideal memory seen through the fault masks.
  task automatic ref_run(input int i, input int depth, input int rl, output exp_t e);
    logic [DW-1:0] m [128];
    logic [DW-1:0] got, want;
    int a, r, w;
    e.cycles = 10 * depth + rl; e.fl = 0; e.faddr = 0; e.felem = 0; e.errs = 0;
    e.rds = 5 * depth; e.wrs = 5 * depth; e.maxa = depth - 1;
    for (int el = 0; el < 6; el++) begin
      case (el)
        0:       begin r = -1; w = 0;  end
        1:       begin r = 0;  w = 1;  end
        2:       begin r = 1;  w = 0;  end
        3:       begin r = 0;  w = 1;  end
        4:       begin r = 1;  w = 0;  end
        default: begin r = 0;  w = -1; end
      endcase
      for (int k = 0; k < depth; k++) begin
        a = (el < 3) ? k : depth - 1 - k;
        if (r >= 0) begin
          want = (r == 1) ? '1 : '0;
          got  = (m[a] & ~sa0[i][a]) | sa1[i][a];
          if (got != want) begin
            if (e.fl == 0) begin e.fl = 1; e.faddr = a; e.felem = el; end
            if (e.errs < 255) e.errs++;
          end
        end
        if (w >= 0) m[a] = (w == 1) ? '1 : '0;
      end
    end
  endtask

  task automatic mon(input int i, input logic rn, bsy, dn, fl, input int fa, fe, ec,
                     input logic c0, c1, input int a0, a1);
    string t;
    exp_t  e;
    t = (i == 0) ? "A" : "B";
    if (!rn) begin
      bcyc[i] = 0; nrd[i] = 0; nwr[i] = 0; maxa[i] = -1; nboth[i] = 0; pbusy[i] = 0;
      return;
    end
    if (bsy) begin
      bcyc[i]++;
      if (!c0) begin nwr[i]++; if (a0 > maxa[i]) maxa[i] = a0; end
      if (!c1) begin nrd[i]++; if (a1 > maxa[i]) maxa[i] = a1; end
      if (!c0 && !c1) nboth[i]++;
    end
    if (pbusy[i] && !bsy && dn) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        chk({t, " unexpected completion"}, 1, 0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk({t, " busy cycles"}, bcyc[i], e.cycles);
        chk({t, " fail"}, fl, e.fl);
        chk({t, " fail_addr"}, fa, e.faddr);
        chk({t, " fail_elem"}, fe, e.felem);
        chk({t, " err_count"}, ec, e.errs);
        chk({t, " reads"}, nrd[i], e.rds);
        chk({t, " writes"}, nwr[i], e.wrs);
        chk({t, " max addr"}, maxa[i], e.maxa);
        chk({t, " rd+wr same cycle"}, nboth[i], 0);
      end
    end
    if (pbusy[i] && !bsy) begin
      bcyc[i] = 0; nrd[i] = 0; nwr[i] = 0; maxa[i] = -1; nboth[i] = 0;
    end
    pbusy[i] = bsy;
  endtask

  always @(negedge clock) begin
    mon(0, reset_n, busy_a, done_a, fail_a, int'(fail_addr_a), int'(fail_elem_a), int'(err_a),
        csb0_a, csb1_a, int'(addr0_a), int'(addr1_a));
    mon(1, reset_n, busy_b, done_b, fail_b, int'(fail_addr_b), int'(fail_elem_b), int'(err_b),
        csb0_b, csb1_b, int'(addr0_b), int'(addr1_b));
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_f) begin
      f_wen_a = 1'($urandom); f_ren_a = 1'($urandom); f_waddr_a = 7'($urandom);
      f_raddr_a = 7'($urandom); f_wdata_a = DW'({$urandom, $urandom}); f_wmask_a = 4'($urandom);
      f_wen_b = 1'($urandom); f_ren_b = 1'($urandom); f_waddr_b = 6'($urandom);
      f_raddr_b = 6'($urandom); f_wdata_b = DW'({$urandom, $urandom}); f_wmask_b = 4'($urandom);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 128; a++) begin sa0[i][a] = '0; sa1[i][a] = '0; end
  endtask

  task automatic start_pulse(input int i);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (i == 0) begin
      chk("A busy after start", busy_a, 1);
      chk("A done cleared", done_a, 0);
      chk("A fail cleared", fail_a, 0);
      chk("A err cleared", err_a, 0);
    end else begin
      chk("B busy after start", busy_b, 1);
      chk("B done cleared", done_b, 0);
    end
  endtask

  task automatic run(input int i, input bit repulse);
    exp_t e;
    int   depth, rl, left;
    depth = (i == 0) ? 128 : 38;
    rl    = (i == 0) ? 1 : 2;
    ref_run(i, depth, rl, e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    start_pulse(i);
    for (int c = 1; c < e.cycles + 40; c++) begin
      tick();
      if (repulse) start_a = (c == 9);
      left = (i == 0) ? q0.size() : q1.size();
      if (left == 0) break;
    end
    left = (i == 0) ? q0.size() : q1.size();
    if (left != 0) begin
      chk((i == 0) ? "A completion timeout" : "B completion timeout", left, 0);
      if (i == 0) q0.delete(); else q1.delete();
    end
    repeat (3) tick();
    chk((i == 0) ? "A done held" : "B done held", (i == 0) ? done_a : done_b, 1);
    chk((i == 0) ? "A busy low" : "B busy low", (i == 0) ? busy_a : busy_b, 0);
  endtask

  initial begin
    ncmp = 0; nfail = 0; rnd_f = 0;
    start_a = 0; start_b = 0;
    f_waddr_a = '0; f_raddr_a = '0; f_wdata_a = '0; f_wmask_a = '1;
    f_waddr_b = '0; f_raddr_b = '0; f_wdata_b = '0; f_wmask_b = '1;
    f_wen_a = 1; f_ren_a = 1; f_wen_b = 1; f_ren_b = 1;
    dout_a = '0; dout_b = '0; d1_b = '0;
    for (int a = 0; a < 128; a++) mem_a[a] = DW'({$urandom, $urandom});
    for (int a = 0; a < 64; a++) mem_b[a] = DW'({$urandom, $urandom});
    for (int i = 0; i < 2; i++) begin
      bcyc[i] = 0; nrd[i] = 0; nwr[i] = 0; maxa[i] = -1; nboth[i] = 0; pbusy[i] = 0;
    end
    clear_faults();

    #2;
    chk("reset csb0 A", csb0_a, 1);
    chk("reset csb1 A", csb1_a, 1);
    chk("reset csb0 B", csb0_b, 1);
    chk("reset csb1 B", csb1_b, 1);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset fail", fail_a, 0);
    chk("reset err_count", err_a, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;

    f_wen_a = 1; f_ren_a = 0; f_waddr_a = 7'h12; f_wdata_a = 40'hA5; f_wmask_a = 4'b1010;
    #1;
    chk("bypass csb0", csb0_a, 0);
    chk("bypass addr0", addr0_a, 7'h12);
    chk("bypass din0", din0_a, 40'hA5);
    chk("bypass wmask0", wmask0_a, 4'b1010);
    chk("bypass csb1 idle", csb1_a, 1);
    f_wen_a = 0; f_ren_a = 1; f_raddr_a = 7'h33;
    #1;
    chk("bypass csb1", csb1_a, 0);
    chk("bypass addr1", addr1_a, 7'h33);
    chk("bypass csb0 idle", csb0_a, 1);
    f_wen_b = 1; f_waddr_b = 6'h25;
    #1;
    chk("bypass B addr0", addr0_b, 6'h25);
    tick();
    chk("f_rdata follows dout1", f_rdata_a, dout_a);

    rnd_f = 1;
    run(0, 1);

    sa1[0][5][3] = 1'b1;
    run(0, 0);
    clear_faults();

    sa0[0][9][$urandom_range(0, DW - 1)] = 1'b1;
    sa1[0][2][$urandom_range(0, DW - 1)] = 1'b1;
    run(0, 0);
    clear_faults();

    for (int a = 0; a < 128; a++) begin sa0[0][a][0] = 1'b1; sa1[0][a][1] = 1'b1; end
    run(0, 0);
    clear_faults();

    sa1[0][5][3] = 1'b1;
    start_pulse(0);
    repeat (399) tick();
    chk("A fail before abort", fail_a, 1);
    reset_n = 0;
    f_wen_a = 1; f_ren_a = 1;
    #1;
    chk("abort csb0", csb0_a, 1);
    chk("abort csb1", csb1_a, 1);
    chk("abort busy", busy_a, 0);
    chk("abort fail", fail_a, 0);
    chk("abort fail_addr", fail_addr_a, 0);
    chk("abort fail_elem", fail_elem_a, 0);
    chk("abort err_count", err_a, 0);
    chk("abort done", done_a, 0);
    tick();
    reset_n = 1;
    clear_faults();
    run(0, 0);

    run(1, 0);
    sa1[1][0][7] = 1'b1;
    sa0[1][37][39] = 1'b1;
    sa1[1][45][0] = 1'b1;
    run(1, 0);
    clear_faults();

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++) begin
        int nf, a, bt;
        nf = $urandom_range(0, 5);
        for (int f = 0; f < nf; f++) begin
          a  = (i == 0) ? $urandom_range(0, 127) : $urandom_range(0, 63);
          bt = $urandom_range(0, DW - 1);
          if ($urandom_range(0, 1) == 1) sa1[i][a][bt] = 1'b1; else sa0[i][a][bt] = 1'b1;
        end
        run(i, 0);
        clear_faults();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_mbist.md
Name: sram_1w1r_mbist

Overview:
- March C- built-in self-test controller that acts as the initiator for one 1W1R OpenRAM macro (freepdk45_sram_1w1r_* family).
- It sits between the functional *_ext wrapper logic and the macro's active-low port pins.
- In IDLE it passes functional traffic through unchanged. While a test runs it owns both macro ports and checks read data against expected values.
- It reports pass/fail, the first failing address and March element, and a saturating error count.

Parameters:
ADDR_WIDTH, 7, macro address width.
DATA_WIDTH, 40, macro data width.
MASK_WIDTH, 4, macro write-mask width; tie to 1 for macros without wmask.
DEPTH, 128, number of words tested, addresses 0..DEPTH-1; may be less than 2^ADDR_WIDTH.
READ_LATENCY, 1, cycles from read request (csb1 low) to dout1 valid; must be 1 or greater.

Ports:
clock  in  1  rising-edge clock shared by both macro ports.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse that begins a test; honoured only in IDLE.
busy  out  1  high while a test runs.
done  out  1  sticky completion flag.
fail  out  1  sticky mismatch flag.
fail_addr  out  ADDR_WIDTH  address of the first mismatch.
fail_elem  out  3  March element (0..5) of the first mismatch.
err_count  out  8  number of mismatching reads, saturates at 255.
f_waddr/f_wdata/f_wen/f_wmask  in  ADDR_WIDTH/DATA_WIDTH/1/MASK_WIDTH  functional write request, active-high.
f_raddr/f_ren  in  ADDR_WIDTH/1  functional read request.
f_rdata  out  DATA_WIDTH  equals dout1.
addr0/din0/wmask0/csb0  out  ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH/1  macro write port; csb0 active-low.
addr1/csb1  out  ADDR_WIDTH/1  macro read port; csb1 active-low.
dout1  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE.
  - busy, done, fail, fail_addr, fail_elem and err_count all go to 0.
  - csb0 and csb1 are forced to 1 while reset_n is low, regardless of the functional inputs.
  - A reset in the middle of a test aborts it with no partial result kept.
- IDLE (combinational bypass):
  - csb0 = ~f_wen, csb1 = ~f_ren.
  - addr0, din0, wmask0 and addr1 follow the corresponding f_* inputs.
- start in IDLE:
  - done, fail, fail_addr, fail_elem and err_count clear on the same edge.
  - busy goes to 1 and the FSM enters RUN.
  - The functional f_* inputs are ignored until the FSM returns to IDLE.
  - start while busy is ignored.
- RUN sequence, ascending (⇑) or descending (⇓) address order:
  - M0 ⇑(w0): 1 cycle per address.
  - M1 ⇑(r0,w1): read cycle then write cycle per address.
  - M2 ⇑(r1,w0): read cycle then write cycle per address.
  - M3 ⇓(r0,w1): read cycle then write cycle per address.
  - M4 ⇓(r1,w0): read cycle then write cycle per address.
  - M5 ⇓(r0): 1 cycle per address.
  - Ascending order is 0..DEPTH-1; descending order is DEPTH-1..0. Addresses at or above DEPTH are never driven.
- Port driving in RUN:
  - Write cycle: csb0=0, csb1=1, din0 = all-0 or all-1, wmask0 all ones.
  - Read cycle: csb1=0, csb0=1.
  - Read and write are never issued in the same cycle.
- DRAIN: after the last M5 read, the FSM waits READ_LATENCY cycles with both csb pins at 1.
- DONE: busy goes to 0 and done goes to 1, and done holds until the next start. The FSM returns to IDLE (bypass) in the same cycle.
- Total busy cycles = 10*DEPTH + READ_LATENCY.
- Compare pipeline:
  - Each read pushes {valid, addr, elem, expected} into a READ_LATENCY-deep shift register.
  - At the output stage, dout1 is compared with expected over the full width.
  - On a mismatch, err_count increments (saturating at 255) and fail is set.
  - fail_addr and fail_elem are captured only when fail was previously 0.
  - A mismatch that lands in the final DRAIN cycle is counted before done rises.

Test Plan:
- Ideal behavioural macro, default parameters, start pulse -> busy high for 1281 cycles, then done=1, fail=0, err_count=0.
- Bit 3 of address 5 stuck at 1 -> fail=1, fail_addr=5, fail_elem=1, err_count=3 (failures in M1, M3 and M5 only).
- Two faulty addresses, 9 stuck-at-0 and 2 stuck-at-1, default parameters -> the ⇑ M1 read of address 2 is the first mismatch (fail_elem=1, fail_addr=2) before the M2 read of address 9 (elem 2). err_count=5: three for address 2, two for address 9 (M2 and M4).
- reset_n pulsed low at cycle 400 of a run, then start -> csb pins go to 1 immediately, all outputs return to 0, and the fresh run completes in 1281 cycles with a clean result.
- start re-pulsed at cycle 10 of a run -> ignored, and completion still lands at cycle 1281.
- Bypass and sizing checks:
  - IDLE: f_wen=1, f_waddr=0x12, f_wdata=0xA5 -> csb0=0 and addr0=0x12 in the same cycle.
  - DEPTH=38, ADDR_WIDTH=6, READ_LATENCY=2 -> busy for 382 cycles and no address above 37 is ever driven.
